// File: rtl/encoder_pkg.sv
// Shared definitions for the priority serializer: width helper, FSM encoding
// and the default request width.
package encoder_pkg;

    localparam int unsigned DEFAULT_WIDTH = 16;

    typedef enum logic {
        IDLE  = 1'b0,
        SERVE = 1'b1
    } state_e;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        int unsigned rem;
        result = 0;
        rem    = value - 1;
        while (rem > 0) begin
            result = result + 1;
            rem    = rem >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/prio_enc.sv
// Combinational priority encoder: reports the index of the winning set bit,
// lowest index first or highest index first.
module prio_enc
    import encoder_pkg::*;
#(
    parameter int unsigned WIDTH     = DEFAULT_WIDTH,
    parameter int unsigned LSB_FIRST = 1,
    localparam int unsigned OUT_W    = clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] req,
    output logic [OUT_W-1:0] idx,
    output logic             any_set
);

    // Scan away from the winning end so the winner is the last write.
    always_comb begin
        idx     = '0;
        any_set = |req;
        for (int i = 0; i < int'(WIDTH); i++) begin
            if (LSB_FIRST != 0) begin
                if (req[int'(WIDTH) - 1 - i]) begin
                    idx = OUT_W'(int'(WIDTH) - 1 - i);
                end
            end else begin
                if (req[i]) begin
                    idx = OUT_W'(i);
                end
            end
        end
    end

endmodule

// File: rtl/prio_serializer.sv
// Accepts a request vector and emits the index of each set bit, one per
// accepted output transfer, in priority order.
module prio_serializer
    import encoder_pkg::*;
#(
    parameter int unsigned WIDTH     = DEFAULT_WIDTH,
    parameter int unsigned LSB_FIRST = 1,
    localparam int unsigned OUT_W    = clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic [WIDTH-1:0] encoder_in,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [OUT_W-1:0] binary_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_last,
    output logic             zero_in
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] pending_q, pending_d;
    logic             zero_in_q, zero_in_d;

    logic [OUT_W-1:0] enc_idx;
    logic             enc_any;
    logic             serving;
    logic             single_bit;
    logic             accept;
    logic             transfer;

    prio_enc #(
        .WIDTH     (WIDTH),
        .LSB_FIRST (LSB_FIRST)
    ) u_prio_enc (
        .req     (pending_q),
        .idx     (enc_idx),
        .any_set (enc_any)
    );

    // Outputs decode registered state only; rst_n forces them quiet while held.
    assign serving    = rst_n && (state_q == SERVE);
    assign single_bit = enc_any && ((pending_q & (pending_q - WIDTH'(1))) == '0);

    assign in_ready   = rst_n && enable && (state_q == IDLE);
    assign out_valid  = serving;
    assign binary_out = serving ? enc_idx : '0;
    assign out_last   = serving && single_bit;
    assign zero_in    = zero_in_q;

    assign accept     = in_valid && in_ready;
    assign transfer   = out_valid && out_ready;

    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        zero_in_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (encoder_in == '0) begin
                        zero_in_d = 1'b1;
                    end else begin
                        pending_d = encoder_in;
                        state_d   = SERVE;
                    end
                end
            end
            SERVE: begin
                if (transfer) begin
                    pending_d = pending_q & ~(WIDTH'(1) << enc_idx);
                    if (out_last) begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            pending_q <= '0;
            zero_in_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            zero_in_q <= zero_in_d;
        end
    end

endmodule

// File: tb/tb_prio_serializer.sv
// Directed bench for prio_serializer; an LSB-first and an MSB-first instance
// share all inputs and are compared against hand-computed indices.
module tb_prio_serializer;

    logic        clk;
    logic        rst_n;
    logic        enable;
    logic [15:0] encoder_in;
    logic        in_valid;
    logic        out_ready;

    logic        l_in_ready, l_out_valid, l_out_last, l_zero_in;
    logic [3:0]  l_bin;
    logic        m_in_ready, m_out_valid, m_out_last, m_zero_in;
    logic [3:0]  m_bin;

    int total;
    int bad;

    prio_serializer #(.WIDTH(16), .LSB_FIRST(1)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .encoder_in (encoder_in),
        .in_valid   (in_valid),
        .in_ready   (l_in_ready),
        .binary_out (l_bin),
        .out_valid  (l_out_valid),
        .out_ready  (out_ready),
        .out_last   (l_out_last),
        .zero_in    (l_zero_in)
    );

    prio_serializer #(.WIDTH(16), .LSB_FIRST(0)) dut_msb (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .encoder_in (encoder_in),
        .in_valid   (in_valid),
        .in_ready   (m_in_ready),
        .binary_out (m_bin),
        .out_valid  (m_out_valid),
        .out_ready  (out_ready),
        .out_last   (m_out_last),
        .zero_in    (m_zero_in)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] vec;
        int          cnt;
        logic [3:0]  first_lsb;
        logic [3:0]  first_msb;
    } vec_t;

    vec_t tbl [6];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        tbl[0] = '{16'h0001,  1,  0,  0};
        tbl[1] = '{16'h8000,  1, 15, 15};
        tbl[2] = '{16'h00F0,  4,  4,  7};
        tbl[3] = '{16'hFFFF, 16,  0, 15};
        tbl[4] = '{16'h0180,  2,  7,  8};
        tbl[5] = '{16'h4002,  2,  1, 14};

        rst_n      = 1'b0;
        enable     = 1'b1;
        encoder_in = '0;
        in_valid   = 1'b0;
        out_ready  = 1'b1;

        // Reset held two cycles
        tick();
        tick();
        chk("rst_out_valid", 64'(l_out_valid), 64'd0);
        chk("rst_binary_out", 64'(l_bin), 64'd0);
        chk("rst_out_last", 64'(l_out_last), 64'd0);
        chk("rst_in_ready", 64'(l_in_ready), 64'd0);
        chk("rst_zero_in", 64'(l_zero_in), 64'd0);
        rst_n = 1'b1;
        #1;
        chk("rel_in_ready", 64'(l_in_ready), 64'd1);
        chk("rel_in_ready_msb", 64'(m_in_ready), 64'd1);

        // One-hot vector
        encoder_in = 16'h0008;
        in_valid   = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("oh_out_valid", 64'(l_out_valid), 64'd1);
        chk("oh_binary_out", 64'(l_bin), 64'd3);
        chk("oh_binary_out_msb", 64'(m_bin), 64'd3);
        chk("oh_out_last", 64'(l_out_last), 64'd1);
        chk("oh_in_ready_busy", 64'(l_in_ready), 64'd0);
        tick();
        chk("oh_in_ready_back", 64'(l_in_ready), 64'd1);
        chk("oh_out_valid_done", 64'(l_out_valid), 64'd0);

        // Multi-bit vector, both priority orders
        begin
            logic [3:0] exp_l [4];
            logic [3:0] exp_m [4];
            exp_l = '{4'd0, 4'd5, 4'd10, 4'd15};
            exp_m = '{4'd15, 4'd10, 4'd5, 4'd0};
            encoder_in = 16'h8421;
            in_valid   = 1'b1;
            tick();
            in_valid = 1'b0;
            for (int k = 0; k < 4; k++) begin
                chk($sformatf("mb_valid_%0d", k), 64'(l_out_valid), 64'd1);
                chk($sformatf("mb_lsb_%0d", k), 64'(l_bin), 64'(exp_l[k]));
                chk($sformatf("mb_msb_%0d", k), 64'(m_bin), 64'(exp_m[k]));
                chk($sformatf("mb_last_%0d", k), 64'(l_out_last), 64'(k == 3));
                chk($sformatf("mb_last_msb_%0d", k), 64'(m_out_last), 64'(k == 3));
                tick();
            end
            chk("mb_idle_valid", 64'(l_out_valid), 64'd0);
            chk("mb_idle_ready", 64'(l_in_ready), 64'd1);
        end

        // Backpressure with a competing in_valid that must be ignored
        encoder_in = 16'h0006;
        in_valid   = 1'b1;
        out_ready  = 1'b0;
        tick();
        encoder_in = 16'hFFFF;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("bp_valid_%0d", k), 64'(l_out_valid), 64'd1);
            chk($sformatf("bp_hold_lsb_%0d", k), 64'(l_bin), 64'd1);
            chk($sformatf("bp_hold_msb_%0d", k), 64'(m_bin), 64'd2);
            chk($sformatf("bp_last_%0d", k), 64'(l_out_last), 64'd0);
            chk($sformatf("bp_in_ready_%0d", k), 64'(l_in_ready), 64'd0);
            tick();
        end
        out_ready = 1'b1;
        chk("bp_emit0", 64'(l_bin), 64'd1);
        chk("bp_emit0_last", 64'(l_out_last), 64'd0);
        tick();
        in_valid = 1'b0;
        chk("bp_emit1", 64'(l_bin), 64'd2);
        chk("bp_emit1_msb", 64'(m_bin), 64'd1);
        chk("bp_emit1_last", 64'(l_out_last), 64'd1);
        tick();
        chk("bp_done_valid", 64'(l_out_valid), 64'd0);
        chk("bp_done_ready", 64'(l_in_ready), 64'd1);

        // Zero vector, then enable low blocks accept
        encoder_in = 16'h0000;
        in_valid   = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("zero_pulse", 64'(l_zero_in), 64'd1);
        chk("zero_no_valid", 64'(l_out_valid), 64'd0);
        chk("zero_in_ready", 64'(l_in_ready), 64'd1);
        tick();
        chk("zero_pulse_end", 64'(l_zero_in), 64'd0);
        enable     = 1'b0;
        encoder_in = 16'h0001;
        in_valid   = 1'b1;
        #1;
        chk("en_low_in_ready", 64'(l_in_ready), 64'd0);
        tick();
        chk("en_low_no_valid", 64'(l_out_valid), 64'd0);
        tick();
        chk("en_low_no_valid2", 64'(l_out_valid), 64'd0);
        in_valid = 1'b0;
        enable   = 1'b1;

        // Reset mid-operation
        encoder_in = 16'hF000;
        in_valid   = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("rm_first", 64'(l_bin), 64'd12);
        tick();
        chk("rm_second", 64'(l_bin), 64'd13);
        rst_n = 1'b0;
        tick();
        chk("rm_valid_gone", 64'(l_out_valid), 64'd0);
        chk("rm_bin_zero", 64'(l_bin), 64'd0);
        rst_n = 1'b1;
        tick();
        chk("rm_still_idle", 64'(l_out_valid), 64'd0);
        encoder_in = 16'h0001;
        in_valid   = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("rm_fresh_valid", 64'(l_out_valid), 64'd1);
        chk("rm_fresh_bin", 64'(l_bin), 64'd0);
        chk("rm_fresh_last", 64'(l_out_last), 64'd1);
        tick();

        // Table of vectors, enable dropped mid-serve to show it does not stall
        for (int t = 0; t < 6; t++) begin
            encoder_in = tbl[t].vec;
            in_valid   = 1'b1;
            tick();
            in_valid = 1'b0;
            enable   = 1'b0;
            chk($sformatf("tb%0d_first_lsb", t), 64'(l_bin), 64'(tbl[t].first_lsb));
            chk($sformatf("tb%0d_first_msb", t), 64'(m_bin), 64'(tbl[t].first_msb));
            for (int k = 0; k < tbl[t].cnt; k++) begin
                chk($sformatf("tb%0d_valid_%0d", t, k), 64'(l_out_valid), 64'd1);
                chk($sformatf("tb%0d_last_%0d", t, k), 64'(l_out_last),
                    64'(k == tbl[t].cnt - 1));
                if (k == tbl[t].cnt - 1) begin
                    chk($sformatf("tb%0d_final_lsb", t), 64'(l_bin), 64'(tbl[t].first_msb));
                    chk($sformatf("tb%0d_final_msb", t), 64'(m_bin), 64'(tbl[t].first_lsb));
                end
                tick();
            end
            chk($sformatf("tb%0d_done", t), 64'(l_out_valid), 64'd0);
            enable = 1'b1;
            #1;
            chk($sformatf("tb%0d_ready", t), 64'(l_in_ready), 64'd1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
